// File: rtl/wta_disparity_seq.sv
// Streaming winner-take-all disparity selector: folds BEATS beats of INPUTS costs
// into the lowest-cost disparity per pixel, with a one-deep held output.
package wta_disparity_pkg;
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction
endpackage

module wta_disparity_seq
    import wta_disparity_pkg::*;
#(
    parameter int WIDTH       = 7,
    parameter int INPUTS      = 8,
    parameter int DISPARITIES = 64,
    localparam int BEATS      = DISPARITIES / INPUTS,
    localparam int DISP_WIDTH = clog2(DISPARITIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*INPUTS-1:0] in_words,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DISP_WIDTH-1:0]   out_disparity,
    output logic [WIDTH-1:0]        out_min_cost
);

    localparam int BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int IDX_W  = clog2(INPUTS);

    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [WIDTH-1:0]      r_run_cost;
    logic [DISP_WIDTH-1:0] r_run_disp;
    logic                  r_out_valid;
    logic [DISP_WIDTH-1:0] r_out_disp;
    logic [WIDTH-1:0]      r_out_cost;

    logic [WIDTH-1:0]      w_loc_cost;
    logic [IDX_W-1:0]      w_loc_idx;
    logic [DISP_WIDTH-1:0] w_cand_disp;
    logic                  w_final;
    logic                  w_accept;
    logic                  w_take;
    logic [WIDTH-1:0]      w_merge_cost;
    logic [DISP_WIDTH-1:0] w_merge_disp;

    // Per-beat argmin; strict compare keeps the lowest local index on ties.
    always_comb begin
        w_loc_cost = in_words[0 +: WIDTH];
        w_loc_idx  = '0;
        for (int i = 1; i < INPUTS; i++) begin
            if (in_words[i*WIDTH +: WIDTH] < w_loc_cost) begin
                w_loc_cost = in_words[i*WIDTH +: WIDTH];
                w_loc_idx  = IDX_W'(i);
            end else begin
                w_loc_cost = w_loc_cost;
                w_loc_idx  = w_loc_idx;
            end
        end
    end

    assign w_cand_disp  = DISP_WIDTH'(r_beat_cnt) * DISP_WIDTH'(INPUTS) + DISP_WIDTH'(w_loc_idx);
    assign w_final      = (r_beat_cnt == BEAT_W'(BEATS - 1));
    // Only the final beat needs the output slot, so only it is held off.
    assign in_ready     = !(w_final && r_out_valid && !out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_take       = (r_beat_cnt == '0) || (w_loc_cost < r_run_cost);
    assign w_merge_cost = w_take ? w_loc_cost : r_run_cost;
    assign w_merge_disp = w_take ? w_cand_disp : r_run_disp;

    // Beat counter and running minimum across the beats of one pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_run_cost <= '0;
            r_run_disp <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= w_final ? '0 : r_beat_cnt + BEAT_W'(1);
            r_run_cost <= w_merge_cost;
            r_run_disp <= w_merge_disp;
        end else begin
            r_beat_cnt <= r_beat_cnt;
            r_run_cost <= r_run_cost;
            r_run_disp <= r_run_disp;
        end
    end

    // Output holding register; a final beat may refill it in the cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_disp  <= '0;
            r_out_cost  <= '0;
        end else if (w_accept && w_final) begin
            r_out_valid <= 1'b1;
            r_out_disp  <= w_merge_disp;
            r_out_cost  <= w_merge_cost;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_disparity = r_out_disp;
    assign out_min_cost  = r_out_cost;

endmodule

// File: tb/tb_wta_disparity_seq.sv
// Scoreboard bench for wta_disparity_seq: a software argmin model queues expected
// results as pixels are driven; a monitor pops and compares on each output handshake.
module tb_wta_disparity_seq;
    localparam int W  = 7;
    localparam int I  = 8;
    localparam int D  = 64;
    localparam int DW = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W*I-1:0] in_words = '0;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_disparity;
    logic [W-1:0]   out_min_cost;

    int   ready_mode = 0;
    logic rnd_ready  = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [W-1:0]    pix [D];
    logic [DW+W-1:0] exp_q [$];

    assign out_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

    wta_disparity_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_words(in_words), .out_valid(out_valid), .out_ready(out_ready),
        .out_disparity(out_disparity), .out_min_cost(out_min_cost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [DW+W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL result_unexpected: got disp=%0d cost=%0d, required no result", out_disparity, out_min_cost);
            end else begin
                e = exp_q.pop_front();
                if ({out_disparity, out_min_cost} !== e)
                    $display("FAIL result: got disp=%0d cost=%0d, required disp=%0d cost=%0d",
                             out_disparity, out_min_cost, e[DW+W-1:W], e[W-1:0]);
                else
                    passed++;
            end
        end
    end

    function automatic logic [DW+W-1:0] model_best();
        int bd;
        logic [W-1:0] bc;
        bd = 0;
        bc = pix[0];
        for (int d = 1; d < D; d++) begin
            if (pix[d] < bc) begin
                bc = pix[d];
                bd = d;
            end
        end
        return {DW'(bd), bc};
    endfunction

    task automatic fill_random(input int lo, input int hi);
        for (int d = 0; d < D; d++) pix[d] = W'($urandom_range(lo, hi));
    endtask

    task automatic send_beat(input int b, input int gap);
        int waited;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < I; i++) in_words[i*W +: W] = pix[b*I+i];
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            $display("FAIL beat_accept_timeout: beat %0d in_ready=%b after %0d cycles, required 1", b, in_ready, waited);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_pixel(input int max_gap);
        for (int b = 0; b < D / I; b++)
            send_beat(b, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ready_mode = 0;
        in_valid = 1'b1;
        in_words = {I{7'd9}};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else passed++;
        total++; if (out_disparity !== 6'd0) $display("FAIL reset_disp: got %0d, required 0", out_disparity); else passed++;
        total++; if (out_min_cost !== 7'd0) $display("FAIL reset_cost: got %0d, required 0", out_min_cost); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else passed++;
    endtask

    task automatic test_ascending();
        ready_mode = 1;
        for (int d = 0; d < D; d++) pix[d] = W'(d);
        exp_q.push_back(model_best());
        send_pixel(0);
        total++;
        if (out_valid !== 1'b1 || out_disparity !== 6'd0 || out_min_cost !== 7'd0)
            $display("FAIL ascending_latency: got valid=%b disp=%0d cost=%0d, required valid=1 disp=0 cost=0",
                     out_valid, out_disparity, out_min_cost);
        else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL ascending_one_cycle: got out_valid=%b, required 0", out_valid); else passed++;
    endtask

    task automatic test_uniform_and_tie();
        ready_mode = 1;
        for (int d = 0; d < D; d++) pix[d] = 7'd100;
        exp_q.push_back(model_best());
        send_pixel(0);
        pix[20] = 7'd3;
        pix[45] = 7'd3;
        exp_q.push_back(model_best());
        send_pixel(0);
        for (int d = 0; d < D; d++) pix[d] = 7'd127;
        pix[63] = 7'd5;
        exp_q.push_back(model_best());
        send_pixel(0);
        wait_drain();
        total++; if (exp_q.size() != 0) $display("FAIL uniform_drain: got %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_backpressure();
        logic [DW+W-1:0] a;
        logic [DW+W-1:0] b;
        ready_mode = 0;
        fill_random(10, 127);
        pix[5] = 7'd2;
        a = model_best();
        exp_q.push_back(a);
        send_pixel(0);
        fill_random(10, 127);
        pix[50] = 7'd1;
        b = model_best();
        exp_q.push_back(b);
        for (int k = 0; k < 7; k++) send_beat(k, 0);
        for (int i = 0; i < I; i++) in_words[i*W +: W] = pix[7*I+i];
        in_valid = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b, required 0", in_ready); else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || {out_disparity, out_min_cost} !== a)
            $display("FAIL bp_hold: got valid=%b disp=%0d cost=%0d, required valid=1 disp=%0d cost=%0d",
                     out_valid, out_disparity, out_min_cost, a[DW+W-1:W], a[W-1:0]);
        else passed++;
        @(posedge clk); #1;
        ready_mode = 1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_release: got %b, required 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || {out_disparity, out_min_cost} !== b)
            $display("FAIL bp_second: got valid=%b disp=%0d cost=%0d, required valid=1 disp=%0d cost=%0d",
                     out_valid, out_disparity, out_min_cost, b[DW+W-1:W], b[W-1:0]);
        else passed++;
        wait_drain();
        total++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        ready_mode = 0;
        fill_random(0, 127);
        send_pixel(0);
        fill_random(0, 127);
        for (int k = 0; k < 4; k++) send_beat(k, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_disparity !== 6'd0 || out_min_cost !== 7'd0)
            $display("FAIL midreset_clear: got valid=%b disp=%0d cost=%0d, required 0/0/0", out_valid, out_disparity, out_min_cost);
        else passed++;
        ready_mode = 1;
        fill_random(20, 127);
        pix[60] = 7'd4;
        exp_q.push_back(model_best());
        send_pixel(0);
        wait_drain();
        total++; if (exp_q.size() != 0) $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    task automatic test_random();
        ready_mode = 2;
        for (int p = 0; p < 1000; p++) begin
            if (p % 4 == 0) fill_random(0, 7);
            else fill_random(0, 127);
            exp_q.push_back(model_best());
            send_pixel((p % 3 == 0) ? 3 : 0);
        end
        ready_mode = 1;
        wait_drain();
        total++; if (exp_q.size() != 0) $display("FAIL random_drain: got %0d pending, required 0", exp_q.size()); else passed++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ascending();
        test_uniform_and_tie();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wta_disparity_seq.md
WTA_DISPARITY_SEQ -- requirements
Module: wta_disparity_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7: bit width of one cost word, unsigned.
REQ-002 The block SHALL have parameter INPUTS, default 8: cost words per input beat; power of two, >= 2.
REQ-003 The block SHALL have parameter DISPARITIES, default 64: cost words per pixel; integer multiple of INPUTS.
REQ-004 The block SHALL derive localparams BEATS = DISPARITIES/INPUTS and DISP_WIDTH = clog2(DISPARITIES), using the shared clog2 function.
REQ-005 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid  input  1  input beat present.
REQ-008 The block SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-009 The block SHALL have port in_words  input  WIDTH*INPUTS  packed costs; word i at bits [i*WIDTH +: WIDTH] is disparity beat*INPUTS+i.
REQ-010 The block SHALL have port out_valid  output  1  result held.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 The block SHALL have port out_disparity  output  DISP_WIDTH  index of minimum cost for the pixel.
REQ-013 The block SHALL have port out_min_cost  output  WIDTH  minimum cost value for the pixel.

Function
REQ-014 A beat SHALL be accepted exactly in cycles where in_valid && in_ready are both high at the rising edge.
REQ-015 A beat counter beat_cnt (0..BEATS-1) SHALL increment on each accepted beat and wrap to 0 after beat BEATS-1; with BEATS==1 every beat is final.
REQ-016 Per beat, the block SHALL compute the combinational argmin of the INPUTS words; among equal minima, the lowest local index wins.
REQ-017 The beat candidate disparity SHALL be beat_cnt*INPUTS + local index, computed at DISP_WIDTH bits without overflow.
REQ-018 On an accepted beat with beat_cnt==0, the running min and running index SHALL be loaded unconditionally from the beat candidate.
REQ-019 On an accepted beat with beat_cnt>0, the running value SHALL be replaced only if candidate cost < running cost (strictly); ties keep the earlier, lower disparity.
REQ-020 On acceptance of the final beat (beat_cnt==BEATS-1), the merged result SHALL be written into the output register and out_valid SHALL rise on the next cycle (latency 1 cycle from final-beat edge).
REQ-021 out_disparity and out_min_cost SHALL remain stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready, out_valid SHALL fall next cycle unless a final beat is accepted in the same cycle, in which case the new result SHALL load and out_valid SHALL stay high.
REQ-023 in_ready SHALL be low only when beat_cnt==BEATS-1 && out_valid && !out_ready; non-final beats SHALL be accepted while a result is pending.
REQ-024 in_ready SHALL be combinational from state and out_ready only, never from in_valid.
REQ-025 Idle cycles (in_valid low) between beats of one pixel SHALL NOT alter the running state or beat_cnt.

Reset
REQ-026 When rst is high at a rising edge: beat_cnt=0, running min/index=0, out_valid=0, out_disparity=0, out_min_cost=0; any partial pixel is discarded.
REQ-027 in_ready SHALL be 1 in the cycle after reset is released.
REQ-028 A beat presented while rst is high SHALL NOT be accepted into the accumulation.

Verification (defaults WIDTH=7, INPUTS=8, DISPARITIES=64)
REQ-029 Ascending costs 0..63 in 8 back-to-back beats, out_ready=1 -> out_valid for one cycle, 1 cycle after the 8th beat; disparity=0, cost=0.
REQ-030 All 64 costs=100 -> disparity=0, cost=100; repeat with cost 3 at disparities 20 and 45 -> disparity=20, cost=3.
REQ-031 Cost 127 everywhere except 5 at disparity 63 -> disparity=63, cost=5; checks final-beat merge and index arithmetic.
REQ-032 out_ready=0 after first pixel; stream second pixel -> beats 0..6 accepted, in_ready=0 at beat 7, first result held stable; raise out_ready -> first result consumed, beat 7 accepted same cycle, second result valid next cycle.
REQ-033 Assert rst after 4 beats of a pixel -> out_valid=0, beat_cnt=0; next 8 beats form a fresh pixel with correct result, no carry-over.
REQ-034 Random costs, random in_valid gaps and out_ready stalls over 1000 pixels -> every result matches a software model (lowest-index minimum); no result lost or duplicated.
